// File: rtl/vram_burst_fetch.sv
// VDP-side burst fetcher: streams 1..BUF_DEPTH VRAM bytes through the
// memory controller's pipelined read port into a line buffer.
//
// Ports:
//   clock, reset_n           : clock, async active-low reset
//   start, start_addr, length: burst request (sampled in IDLE only)
//   busy, done               : burst in flight / one-cycle completion pulse
//   rd_index, rd_data        : line buffer read port, 1-cycle latency
//   vdp_addr, vdp_read_rq,
//   vdp_pipeline_reads       : request side of the controller read port
//   vdp_read_ack, vdp_data   : response side of the controller read port
module vram_burst_fetch #(
  parameter int BUF_DEPTH = 32,
  parameter int IDX_W     = 5,
  parameter int LEN_W     = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [13:0]      start_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rd_index,
  output logic [7:0]       rd_data,
  output logic [13:0]      vdp_addr,
  output logic             vdp_read_rq,
  output logic             vdp_pipeline_reads,
  input  logic             vdp_read_ack,
  input  logic [7:0]       vdp_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SKIP,
    S_STREAM,
    S_FIN
  } state_t;

  state_t st;

  logic [13:0]      addr_q;
  logic [13:0]      addr_r;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] nidx;
  logic [LEN_W-1:0] wr_idx;
  logic [LEN_W-1:0] wnext;
  logic             issue;
  logic             ack_go;
  logic             we;
  logic [IDX_W-1:0] waddr;

  logic [7:0] mem [BUF_DEPTH];

  assign len_c    = (length > LEN_W'(BUF_DEPTH))
                  ? LEN_W'(BUF_DEPTH) : length;
  assign last_idx = len_q - LEN_W'(1);
  assign wnext    = wr_idx + LEN_W'(1);
  // nidx is the next burst index whose address still has to go out
  assign issue    = (nidx <= last_idx);

  // Index 1 must be on the bus in the ack cycle itself so that its
  // data lands two cycles later, right after the duplicate byte.
  assign ack_go   = (st == S_WAIT) && vdp_read_ack &&
                    (len_q != LEN_W'(1));
  assign vdp_addr = ack_go ? (addr_q + 14'd1) : addr_r;

  assign we    = ((st == S_WAIT) && vdp_read_ack) ||
                 (st == S_STREAM);
  assign waddr = (st == S_STREAM) ? wnext[IDX_W-1:0] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st                 <= S_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      vdp_read_rq        <= 1'b0;
      vdp_pipeline_reads <= 1'b0;
      addr_q             <= '0;
      addr_r             <= '0;
      len_q              <= '0;
      nidx               <= '0;
      wr_idx             <= '0;
    end else begin
      done        <= 1'b0;
      vdp_read_rq <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              addr_q             <= start_addr;
              addr_r             <= start_addr;
              len_q              <= len_c;
              wr_idx             <= '0;
              nidx               <= LEN_W'(1);
              busy               <= 1'b1;
              vdp_read_rq        <= 1'b1;
              vdp_pipeline_reads <= (len_c >= LEN_W'(2));
              st                 <= S_REQ;
            end
          end
        end
        S_REQ: begin
          st <= S_WAIT;
        end
        S_WAIT: begin
          if (vdp_read_ack) begin
            if (len_q == LEN_W'(1)) begin
              done               <= 1'b1;
              busy               <= 1'b0;
              vdp_pipeline_reads <= 1'b0;
              st                 <= S_FIN;
            end else begin
              // index 1 went out combinationally this cycle
              if (last_idx >= LEN_W'(2)) begin
                addr_r <= addr_q + 14'd2;
                nidx   <= LEN_W'(3);
              end else begin
                addr_r             <= addr_q + 14'd1;
                vdp_pipeline_reads <= 1'b0;
              end
              st <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (issue) begin
            addr_r <= addr_q + 14'(nidx);
            nidx   <= nidx + LEN_W'(1);
          end else begin
            vdp_pipeline_reads <= 1'b0;
          end
          st <= S_STREAM;
        end
        S_STREAM: begin
          if (issue) begin
            addr_r <= addr_q + 14'(nidx);
            nidx   <= nidx + LEN_W'(1);
          end else begin
            vdp_pipeline_reads <= 1'b0;
          end
          wr_idx <= wnext;
          if (wnext == last_idx) begin
            done               <= 1'b1;
            busy               <= 1'b0;
            vdp_pipeline_reads <= 1'b0;
            st                 <= S_FIN;
          end
        end
        S_FIN: begin
          st <= S_IDLE;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= vdp_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: tb/tb_vram_burst_fetch.sv
// Directed bench for vram_burst_fetch with a behavioural model of the
// memory controller's pipelined read port.
module tb_vram_burst_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [5:0]  length = '0;
  logic        busy;
  logic        done;
  logic [4:0]  rd_index = '0;
  logic [7:0]  rd_data;
  logic [13:0] vdp_addr;
  logic        vdp_read_rq;
  logic        vdp_pipeline_reads;
  logic        vdp_read_ack = 1'b0;
  logic [7:0]  vdp_data = 8'hEE;

  vram_burst_fetch #(
    .BUF_DEPTH(32),
    .IDX_W(5),
    .LEN_W(6)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .start_addr(start_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .rd_index(rd_index),
    .rd_data(rd_data),
    .vdp_addr(vdp_addr),
    .vdp_read_rq(vdp_read_rq),
    .vdp_pipeline_reads(vdp_pipeline_reads),
    .vdp_read_ack(vdp_read_ack),
    .vdp_data(vdp_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;

  function automatic logic [7:0] vram(input logic [13:0] a);
    if (a == 14'h0123) return 8'h5A;
    if (a >= 14'h1000 && a <= 14'h101F)
      return 8'(a - 14'h1000) ^ 8'hA5;
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
  endfunction

  // controller model: inputs change at negedge, bus sampled 1 later
  int          cst = 0;
  int          cnt = 0;
  logic [13:0] sa_m = '0;
  logic [13:0] a1 = '0, a2 = '0;
  logic        p1 = 1'b0, p2 = 1'b0, rq1 = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) cst = 0;
    vdp_read_ack = 1'b0;
    vdp_data = 8'hEE;
    if (cst == 0 && rq1 && reset_n) begin
      cnt = ack_delay;
      sa_m = a1;
      cst = 1;
    end
    if (cst == 1) begin
      if (cnt == 0) begin
        vdp_read_ack = 1'b1;
        vdp_data = vram(sa_m);
        cst = 2;
      end else begin
        cnt--;
      end
    end else if (cst == 2) begin
      vdp_data = vram(sa_m);
      cst = 3;
    end else if (cst == 3) begin
      if (p2) vdp_data = vram(a2);
      else cst = 0;
    end
    #1;
    a2 = a1; a1 = vdp_addr;
    p2 = p1; p1 = vdp_pipeline_reads;
    rq1 = vdp_read_rq;
  end

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int idx,
                        input logic [7:0] exp);
    rd_index = 5'(idx);
    step();
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  int          cyc, ack_at, done_at, rqs, pipes;
  logic        pre_ok, busy_done;
  logic [13:0] addrs[$];

  task automatic burst(input logic [13:0] sa, input logic [5:0] ln,
                       input logic spam);
    start = 1'b1; start_addr = sa; length = ln;
    step();
    start = 1'b0;
    cyc = 0; ack_at = -1; done_at = -1; rqs = 0; pipes = 0;
    pre_ok = 1'b1; busy_done = 1'b1;
    addrs.delete();
    while (done_at < 0 && cyc < 200) begin
      if (vdp_read_rq) rqs++;
      if (vdp_pipeline_reads) pipes++;
      if (vdp_read_ack && ack_at < 0) ack_at = cyc;
      if (ack_at < 0 && vdp_addr != sa) pre_ok = 1'b0;
      if (ack_at >= 0 && vdp_pipeline_reads) addrs.push_back(vdp_addr);
      if (done) begin
        done_at = cyc;
        busy_done = busy;
      end
      start = spam && (cyc == 2 || cyc == 3);
      start_addr = 14'h0000;
      length = 6'd1;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", {31'h0, done_at >= 0}, 32'h1);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rq", {31'h0, vdp_read_rq}, 32'h0);
    chk("rst_pipe", {31'h0, vdp_pipeline_reads}, 32'h0);
    chk("rst_addr", {18'h0, vdp_addr}, 32'h0);
    chk("rst_rd", {24'h0, rd_data}, 32'h0);
    reset_n = 1'b1;
    step();

    // single byte
    ack_delay = 0;
    burst(14'h0123, 6'd1, 1'b0);
    chk("one_rq", rqs, 1);
    chk("one_pipe", pipes, 0);
    chk("one_done_lat", done_at - ack_at, 1);
    chk("one_busy_at_done", {31'h0, busy_done}, 32'h0);
    rd_chk("one_buf0", 0, 8'h5A);

    // full burst
    burst(14'h1000, 6'd32, 1'b0);
    chk("full_rq", rqs, 1);
    chk("full_done_lat", done_at - ack_at, 33);
    chk("full_pre_addr", {31'h0, pre_ok}, 32'h1);
    chk("full_naddr", addrs.size(), 31);
    for (int i = 0; i < 31 && i < addrs.size(); i++)
      chk($sformatf("full_addr%0d", i + 1), {18'h0, addrs[i]},
          32'h1000 + i + 1);
    for (int i = 0; i < 32; i++)
      rd_chk($sformatf("full_buf%0d", i), i, 8'(i) ^ 8'hA5);

    // length 2, late ack
    ack_delay = 5;
    burst(14'h2000, 6'd2, 1'b0);
    ack_delay = 0;
    chk("l2_ack_cyc", ack_at, 6);
    chk("l2_pre_addr", {31'h0, pre_ok}, 32'h1);
    chk("l2_naddr", addrs.size(), 1);
    if (addrs.size() > 0)
      chk("l2_addr1", {18'h0, addrs[0]}, 32'h2001);
    chk("l2_done_lat", done_at - ack_at, 3);
    rd_chk("l2_buf0", 0, vram(14'h2000));
    rd_chk("l2_buf1", 1, vram(14'h2001));

    // address wrap
    burst(14'h3FFE, 6'd4, 1'b0);
    chk("wrap_pre_addr", {31'h0, pre_ok}, 32'h1);
    chk("wrap_naddr", addrs.size(), 3);
    if (addrs.size() == 3) begin
      chk("wrap_a1", {18'h0, addrs[0]}, 32'h3FFF);
      chk("wrap_a2", {18'h0, addrs[1]}, 32'h0000);
      chk("wrap_a3", {18'h0, addrs[2]}, 32'h0001);
    end
    rd_chk("wrap_b0", 0, vram(14'h3FFE));
    rd_chk("wrap_b1", 1, vram(14'h3FFF));
    rd_chk("wrap_b2", 2, vram(14'h0000));
    rd_chk("wrap_b3", 3, vram(14'h0001));

    // zero length, then clamp
    burst(14'h0400, 6'd0, 1'b0);
    chk("zero_done_cyc", done_at, 0);
    chk("zero_rq", rqs, 0);
    burst(14'h0500, 6'd40, 1'b0);
    chk("clamp_done_lat", done_at - ack_at, 33);
    chk("clamp_naddr", addrs.size(), 31);
    rd_chk("clamp_b31", 31, vram(14'h051F));
    rd_chk("clamp_b0", 0, vram(14'h0500));

    // reset mid-stream
    start = 1'b1; start_addr = 14'h1000; length = 6'd32;
    step();
    start = 1'b0;
    cyc = 0;
    while (!vdp_read_ack && cyc < 50) begin
      step();
      cyc++;
    end
    chk("mid_ack_seen", {31'h0, vdp_read_ack}, 32'h1);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_done", {31'h0, done}, 32'h0);
    chk("mid_rq", {31'h0, vdp_read_rq}, 32'h0);
    chk("mid_pipe", {31'h0, vdp_pipeline_reads}, 32'h0);
    chk("mid_addr", {18'h0, vdp_addr}, 32'h0);
    chk("mid_rd", {24'h0, rd_data}, 32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();
    burst(14'h0123, 6'd1, 1'b0);
    chk("post_rq", rqs, 1);
    chk("post_done_lat", done_at - ack_at, 1);
    rd_chk("post_buf0", 0, 8'h5A);

    // start while busy
    burst(14'h0200, 6'd8, 1'b1);
    chk("spam_rq", rqs, 1);
    chk("spam_done_lat", done_at - ack_at, 9);
    chk("spam_naddr", addrs.size(), 7);
    if (addrs.size() == 7)
      chk("spam_a7", {18'h0, addrs[6]}, 32'h0207);
    rqs = 0;
    repeat (4) begin
      if (vdp_read_rq || busy) rqs++;
      step();
    end
    chk("spam_no_queue", rqs, 0);
    rd_chk("spam_b0", 0, vram(14'h0200));
    rd_chk("spam_b7", 7, vram(14'h0207));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_burst_fetch.md
Name: vram_burst_fetch

Overview:
- Upstream VDP-side requester for the external memory controller's VDP read port.
- Fetches a burst of 1..BUF_DEPTH consecutive VRAM bytes using the controller's pipelined read mode.
- Stores the bytes in an internal line buffer, which the VDP renderer reads by index after `done`.
- Used for pattern-row and sprite-attribute prefetch.

Parameters:
- BUF_DEPTH, 32: line buffer size in bytes; power of two, ≥2.
- IDX_W, 5: log2(BUF_DEPTH); width of the buffer index.
- LEN_W, 6: width of `length`; must satisfy 2^LEN_W > BUF_DEPTH.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a burst; sampled only in IDLE.
- start_addr  in  14  VRAM byte address of the first byte.
- length  in  LEN_W  byte count, 0..BUF_DEPTH.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse when the buffer holds the whole burst.
- rd_index  in  IDX_W  buffer read index.
- rd_data  out  8  buffer[rd_index], registered, 1-cycle latency.
- vdp_addr  out  14  VRAM byte address to the controller.
- vdp_read_rq  out  1  one-cycle read request pulse.
- vdp_pipeline_reads  out  1  keeps the controller streaming reads.
- vdp_read_ack  in  1  first-byte ack from the controller.
- vdp_data  in  8  byte from the controller (its vdp_data_out).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, vdp_read_rq and vdp_pipeline_reads =0; vdp_addr=0; rd_data=0; counters=0. Buffer contents are undefined.
- Reset mid-burst aborts immediately. Late acks and data arriving after reset are ignored.
- Controller timing contract (the ack is seen in cycle A):
  - vdp_data in cycle A = byte at start_addr.
  - vdp_data in cycle A+1 = the same byte again; discard it.
  - From A+2 on, vdp_data in cycle n = byte at the vdp_addr driven in cycle n-2.
  - The controller stops streaming in the cycle it samples vdp_pipeline_reads=0 (call it cycle m). Data in m+1 is still valid and corresponds to the address driven in m-1.
- IDLE:
  - On start=1 with length=0: no memory access; done pulses next cycle; stay IDLE.
  - On start=1 with length≥1: latch start_addr into addr_q and length into len_q (values above BUF_DEPTH clamp to BUF_DEPTH). Set wr_idx=0, busy=1, go to REQ.
- REQ (1 cycle):
  - vdp_read_rq=1; vdp_addr=addr_q.
  - vdp_pipeline_reads = (len_q≥2).
  - Go to WAIT.
- WAIT:
  - Hold vdp_addr=addr_q and vdp_pipeline_reads unchanged; no timeout.
  - On vdp_read_ack: write vdp_data to buf[0].
  - If len_q=1, go to FIN.
  - Otherwise drive vdp_addr=addr_q+1, set issued=1, go to SKIP.
- SKIP (1 cycle):
  - Discard vdp_data.
  - Drive the next address (addr_q+issued+1, issued++) while issued<len_q-1.
  - Otherwise drop vdp_pipeline_reads. Go to STREAM.
- STREAM, each cycle:
  - Write vdp_data to buf[wr_idx+1], wr_idx++.
  - Issue addresses as in SKIP. vdp_pipeline_reads falls in the cycle after the last address (index len_q-1) was driven.
  - When the write at index len_q-1 completes, go to FIN.
- FIN: done=1 for 1 cycle; busy→0 in the same cycle; vdp_pipeline_reads=0; go to IDLE.
- Address arithmetic is 14-bit modulo: 3FFF+1 wraps to 0000.
- vdp_read_ack outside WAIT is ignored.
- start while busy is ignored and not queued.
- The buffer read port is independent of the fetch; reading during a burst returns old or new data, with no hazard protection.
- vdp_read_rq is never high for more than 1 cycle per burst.

Test Plan:
- Single byte: VRAM[0x0123]=0x5A; start, start_addr=0x0123, length=1. Expect:
  - One vdp_read_rq pulse and vdp_pipeline_reads never high.
  - done one cycle after ack.
  - rd_index=0 gives rd_data=0x5A next cycle.
- Full burst: VRAM[0x1000+i]=i^0xA5; length=32. Expect:
  - buf[i]=i^0xA5 for i=0..31.
  - done 33 cycles after ack.
  - vdp_addr sequence 0x1000,0x1001..0x101F, each driven exactly once after ack.
- Length 2 with the ack delayed by 5 cycles (controller busy with a CPU access). Expect:
  - vdp_addr stays 0x2000 until ack, then 0x2001 for one cycle.
  - vdp_pipeline_reads falls at A+1.
  - buf[0..1] correct.
- Wrap: start_addr=0x3FFE, length=4. Expect vdp_addr 0x3FFE,0x3FFF,0x0000,0x0001 and the buffer holding those bytes.
- length=0 gives done next cycle with no vdp_read_rq. Then length=40 clamps to 32 bytes.
- Robustness, two cases:
  - Assert reset_n=0 mid-STREAM: outputs go to their reset values immediately. A new start after release completes correctly.
  - start during busy has no effect.
